// File: rtl/axi4_burst_master.sv
// axi4_burst_master
//
// Command-driven AXI4 master. One command (start byte address + beat count, read or
// write) is split into INCR bursts of at most MAX_BURST beats that never cross a
// 4 KB page. Only one burst is outstanding at a time. Read data is forwarded
// combinationally to a valid/ready stream; write data is taken combinationally
// from a valid/ready stream.
//
// Optional feature: define AXI_MASTER_TIMEOUT_EN to enable a watchdog that aborts
// the command with done_err=1 after TIMEOUT_CYC cycles without an AXI handshake.
// Without the macro the FSM waits indefinitely.
//
// Ports
//   aclk, aresetn                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_write, cmd_addr, cmd_beats   direction, BYTES-aligned start address, beat count
//   done, done_err                   one-cycle completion pulse and its error flag
//   m_rdata/m_rvalid/m_rready/m_rlast  read data stream, m_rlast on final command beat
//   s_wdata/s_wvalid/s_wready        write data stream
//   m_axi_aw*, m_axi_w*, m_axi_b*    AXI4 write channels
//   m_axi_ar*, m_axi_r*              AXI4 read channels
module axi4_burst_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 512,
  parameter int MAX_BURST   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [15:0]               cmd_beats,
  output logic                      done,
  output logic                      done_err,
  output logic [DATA_WIDTH-1:0]     m_rdata,
  output logic                      m_rvalid,
  input  logic                      m_rready,
  output logic                      m_rlast,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_AR, S_RDATA, S_AW, S_WDATA, S_WRESP, S_FIN
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             rem_q, rem_d;
  logic                    write_q, write_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    last_burst_q, last_burst_d;
  logic                    err_q, err_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    done_q, done_d;
  logic                    done_err_q, done_err_d;
  logic                    arvalid_q, arvalid_d;
  logic                    awvalid_q, awvalid_d;
  logic                    bready_q, bready_d;

  logic [12:0]             page_room;
  logic [16:0]             burst_beats;
  logic                    burst_end;

  // Beats left before the 4 KB page boundary, and the resulting burst size.
  always_comb begin
    page_room   = (13'h1000 - {1'b0, addr_q[11:0]}) >> OFF_W;
    burst_beats = {1'b0, rem_q};
    if (burst_beats > 17'(MAX_BURST)) burst_beats = 17'(MAX_BURST);
    if (burst_beats > {4'b0, page_room}) burst_beats = {4'b0, page_room};
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             axi_hs;
  logic             tmo_active;
  logic             tmo_hit;

  // Watchdog restarts on any AXI handshake and only runs while waiting on the bus.
  always_comb begin
    axi_hs = (arvalid_q && m_axi_arready) || (awvalid_q && m_axi_awready) ||
             (m_axi_wvalid && m_axi_wready) || (m_axi_rvalid && m_axi_rready) ||
             (bready_q && m_axi_bvalid);
    tmo_active = (state_q == S_AR) || (state_q == S_AW) || (state_q == S_RDATA) ||
                 (state_q == S_WDATA) || (state_q == S_WRESP);
    tmo_d   = (!tmo_active || axi_hs) ? '0 : tmo_q + TMO_W'(1);
    tmo_hit = tmo_active && !axi_hs && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  end
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    write_d      = write_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    last_burst_d = last_burst_q;
    err_d        = err_q;
    cmd_ready_d  = cmd_ready_q;
    done_d       = 1'b0;
    done_err_d   = 1'b0;
    arvalid_d    = arvalid_q;
    awvalid_d    = awvalid_q;
    bready_d     = bready_q;
    burst_end    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          rem_d       = cmd_beats;
          write_d     = cmd_write;
          if ((cmd_addr[OFF_W-1:0] != '0) || (cmd_beats == 16'd0)) begin
            err_d      = 1'b1;
            state_d    = S_FIN;
            done_d     = 1'b1;
            done_err_d = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      // Burst length is registered here so AR/AW see stable addr/len from their first cycle.
      S_CALC: begin
        len_d        = 8'(burst_beats - 17'd1);
        cnt_d        = 8'd0;
        last_burst_d = (burst_beats == {1'b0, rem_q});
        if (write_q) begin
          awvalid_d = 1'b1;
          state_d   = S_AW;
        end else begin
          arvalid_d = 1'b1;
          state_d   = S_AR;
        end
      end
      S_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RDATA;
        end
      end
      // The burst ends on our own beat count; a disagreeing RLAST only flags an error.
      S_RDATA: begin
        if (m_axi_rvalid && m_axi_rready) begin
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
          if (m_axi_rlast != (cnt_q == len_q)) err_d = 1'b1;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) burst_end = 1'b1;
        end
      end
      S_AW: begin
        if (m_axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = S_WDATA;
        end
      end
      S_WDATA: begin
        if (m_axi_wvalid && m_axi_wready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) begin
            state_d  = S_WRESP;
            bready_d = 1'b1;
          end
        end
      end
      S_WRESP: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp != 2'b00) err_d = 1'b1;
          burst_end = 1'b1;
        end
      end
      S_FIN: begin
        err_d       = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (burst_end) begin
      addr_d = addr_q + (ADDR_WIDTH'({1'b0, len_q} + 9'd1) << OFF_W);
      rem_d  = rem_q - ({8'd0, len_q} + 16'd1);
      if (last_burst_q) begin
        state_d    = S_FIN;
        done_d     = 1'b1;
        done_err_d = err_d;
      end else begin
        state_d = S_CALC;
      end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    if (tmo_hit) begin
      arvalid_d  = 1'b0;
      awvalid_d  = 1'b0;
      bready_d   = 1'b0;
      err_d      = 1'b1;
      state_d    = S_FIN;
      done_d     = 1'b1;
      done_err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      write_q      <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      last_burst_q <= 1'b0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      write_q      <= write_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      last_burst_q <= last_burst_d;
      err_q        <= err_d;
      cmd_ready_q  <= cmd_ready_d;
      done_q       <= done_d;
      done_err_q   <= done_err_d;
      arvalid_q    <= arvalid_d;
      awvalid_q    <= awvalid_d;
      bready_q     <= bready_d;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign done          = done_q;
  assign done_err      = done_err_q;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_bready  = bready_q;

  // Stream pass-through, gated so nothing moves outside the matching data phase.
  assign m_axi_rready  = (state_q == S_RDATA) && m_rready;
  assign m_rvalid      = (state_q == S_RDATA) && m_axi_rvalid;
  assign m_rdata       = m_axi_rdata;
  assign m_rlast       = (state_q == S_RDATA) && last_burst_q && (cnt_q == len_q);

  assign m_axi_wvalid  = (state_q == S_WDATA) && s_wvalid;
  assign s_wready      = (state_q == S_WDATA) && m_axi_wready;
  assign m_axi_wdata   = s_wdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state_q == S_WDATA) && (cnt_q == len_q);

endmodule

// File: tb/tb_axi4_burst_master.sv
`timescale 1ns/1ps
module tb_axi4_burst_master;
  localparam int AW = 32;
  localparam int DW = 512;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic            cmd_valid, cmd_ready, cmd_write, done, done_err;
  logic [AW-1:0]   cmd_addr;
  logic [15:0]     cmd_beats;
  logic [DW-1:0]   m_rdata, s_wdata;
  logic            m_rvalid, m_rready, m_rlast, s_wvalid, s_wready;
  logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
  logic [7:0]      m_axi_awlen, m_axi_arlen;
  logic            m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]      m_axi_bresp, m_axi_rresp;
  logic            m_axi_bvalid, m_axi_bready;
  logic            m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi4_burst_master dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .done(done), .done_err(done_err),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return {16{32'hC0DE_0000 ^ 32'(i)}};
  endfunction

  // ---------------- memory slave model (reset together with the master) ----------------
  logic [DW-1:0] mem [0:255];
  logic [7:0]    r_ptr, r_left, w_ptr, w_left;
  logic          r_busy;
  logic [1:0]    w_st;
  logic          bresp_err, rresp_err, aw_block;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      m_axi_arready <= 1'b0; m_axi_rvalid <= 1'b0; m_axi_rdata <= '0;
      m_axi_rresp <= 2'b00; m_axi_rlast <= 1'b0; r_busy <= 1'b0;
      r_ptr <= '0; r_left <= '0;
      m_axi_awready <= 1'b0; m_axi_wready <= 1'b0; m_axi_bvalid <= 1'b0;
      m_axi_bresp <= 2'b00; w_st <= 2'd0; w_ptr <= '0; w_left <= '0;
    end else begin
      if (!r_busy) begin
        m_axi_arready <= 1'b1;
        if (m_axi_arvalid && m_axi_arready) begin
          m_axi_arready <= 1'b0;
          r_busy       <= 1'b1;
          r_ptr        <= m_axi_araddr[13:6];
          r_left       <= m_axi_arlen;
          m_axi_rvalid <= 1'b1;
          m_axi_rdata  <= mem[m_axi_araddr[13:6]];
          m_axi_rresp  <= rresp_err ? 2'b10 : 2'b00;
          m_axi_rlast  <= (m_axi_arlen == 8'd0);
        end
      end else if (m_axi_rvalid && m_axi_rready) begin
        if (r_left == 8'd0) begin
          m_axi_rvalid <= 1'b0;
          m_axi_rlast  <= 1'b0;
          r_busy       <= 1'b0;
        end else begin
          r_ptr       <= r_ptr + 8'd1;
          m_axi_rdata <= mem[r_ptr + 8'd1];
          r_left      <= r_left - 8'd1;
          m_axi_rlast <= (r_left == 8'd1);
        end
      end
      case (w_st)
        2'd0: begin
          m_axi_awready <= !aw_block;
          if (m_axi_awvalid && m_axi_awready) begin
            m_axi_awready <= 1'b0;
            w_ptr         <= m_axi_awaddr[13:6];
            w_left        <= m_axi_awlen;
            m_axi_wready  <= 1'b1;
            w_st          <= 2'd1;
          end
        end
        2'd1: begin
          if (m_axi_wvalid && m_axi_wready) begin
            mem[w_ptr] <= m_axi_wdata;
            w_ptr      <= w_ptr + 8'd1;
            if (w_left == 8'd0) begin
              m_axi_wready <= 1'b0;
              m_axi_bvalid <= 1'b1;
              m_axi_bresp  <= bresp_err ? 2'b10 : 2'b00;
              w_st         <= 2'd2;
            end else begin
              w_left <= w_left - 8'd1;
            end
          end
        end
        default: begin
          if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bvalid <= 1'b0;
            w_st         <= 2'd0;
          end
        end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } axreq_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  axreq_t        exp_ar[$], exp_aw[$];
  beat_t         exp_rd[$], exp_w[$];
  logic          exp_done[$];
  logic [DW-1:0] wq[$];
  logic [DW-1:0] model_mem [0:255];
  int            n_pass = 0, n_total = 0, w_beats = 0;
  logic          av_seen = 1'b0;
  logic          rnd_rready = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  axreq_t mon_req;
  beat_t  mon_beat;
  logic   mon_err;
  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_axi_arvalid || m_axi_awvalid) av_seen = 1'b1;
      if (m_axi_arvalid && m_axi_arready) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
        else begin
          mon_req = exp_ar.pop_front();
          $display("AR   addr=%h len=%0d", m_axi_araddr, m_axi_arlen);
          chk("ar_addr", m_axi_araddr, mon_req.addr);
          chk("ar_len", m_axi_arlen, mon_req.len);
        end
      end
      if (m_axi_awvalid && m_axi_awready) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
        else begin
          mon_req = exp_aw.pop_front();
          $display("AW   addr=%h len=%0d", m_axi_awaddr, m_axi_awlen);
          chk("aw_addr", m_axi_awaddr, mon_req.addr);
          chk("aw_len", m_axi_awlen, mon_req.len);
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_beats++;
        if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
        else begin
          mon_beat = exp_w.pop_front();
          $display("W    data=%h.. last=%b", m_axi_wdata[31:0], m_axi_wlast);
          chk("w_data", m_axi_wdata, mon_beat.data);
          chk("w_last", m_axi_wlast, mon_beat.last);
          chk("w_strb", m_axi_wstrb, {(DW/8){1'b1}});
        end
      end
      if (m_rvalid && m_rready) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          mon_beat = exp_rd.pop_front();
          $display("RD   data=%h.. last=%b", m_rdata[31:0], m_rlast);
          chk("rd_data", m_rdata, mon_beat.data);
          chk("rd_last", m_rlast, mon_beat.last);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          mon_err = exp_done.pop_front();
          $display("DONE err=%b", done_err);
          chk("done_err", done_err, mon_err);
        end
      end
    end
  end

  // ---------------- stream drivers ----------------
  initial begin
    m_rready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      m_rready = rnd_rready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    logic w_fire;
    s_wvalid = 1'b0;
    s_wdata  = '0;
    forever begin
      @(negedge aclk);
      w_fire = s_wvalid && s_wready;
      @(posedge aclk); #1;
      if (w_fire && wq.size() > 0) void'(wq.pop_front());
      if (wq.size() > 0 && $urandom_range(0, 3) != 0) begin
        s_wvalid = 1'b1;
        s_wdata  = wq[0];
      end else begin
        s_wvalid = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_ax(input logic w, input logic [AW-1:0] a, input logic [7:0] l);
    axreq_t r;
    r.addr = a;
    r.len  = l;
    if (w) exp_aw.push_back(r); else exp_ar.push_back(r);
  endtask

  task automatic push_rd(input int first, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = model_mem[first + i];
      b.last = (i == n - 1);
      exp_rd.push_back(b);
    end
  endtask

  // Queues write data; burst_last lists the beat indices that end a burst.
  task automatic push_wr(input int first, input int n, input int seed, input int bl0, input int bl1);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {16{32'hAB00_0000 + 32'(seed + i)}};
      b.last = (i == bl0) || (i == bl1);
      wq.push_back(b.data);
      exp_w.push_back(b);
      model_mem[first + i] = b.data;
    end
  endtask

  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [15:0] n);
    logic ok;
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_beats = n;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    $display("CMD  write=%b addr=%h beats=%0d", w, a, n);
    chk("cmd_accepted", ok, 1);
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge aclk);
      if (done) begin cyc = i; break; end
    end
    chk("done_seen", (cyc > 0), 1);
    @(posedge aclk); #1;
    chk("done_one_cycle", done, 0);
    chk("queues_drained",
        exp_ar.size() + exp_aw.size() + exp_rd.size() + exp_w.size() + exp_done.size(), 0);
  endtask

  task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [15:0] n,
                         input int budget, output int cyc);
    send_cmd(w, a, n);
    wait_done(budget, cyc);
  endtask

  function automatic logic [91:0] out_vec();
    return {cmd_ready, done, done_err, m_axi_arvalid, m_axi_awvalid, m_axi_bready,
            m_axi_rready, m_axi_wvalid, m_rvalid, s_wready, m_rlast, m_axi_wlast,
            m_axi_arlen, m_axi_awlen, m_axi_araddr, m_axi_awaddr};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int w0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_beats = '0;
    bresp_err = 1'b0; rresp_err = 1'b0; aw_block = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = pat(i);
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_outputs", out_vec(), 0);
    #2 aresetn = 1'b1;
    rnd_rready = 1'b1;

    // 1: single aligned burst
    push_ax(0, 32'h1000, 8'd3); push_rd(64, 4); exp_done.push_back(1'b0);
    run_cmd(0, 32'h1000, 16'd4, 200, cyc);

    // 2: write crossing a 4 KB page, then read it back
    push_ax(1, 32'h0FC0, 8'd0); push_ax(1, 32'h1000, 8'd1);
    push_wr(63, 3, 0, 0, 2); exp_done.push_back(1'b0);
    run_cmd(1, 32'h0FC0, 16'd3, 300, cyc);
    push_ax(0, 32'h0FC0, 8'd0); push_ax(0, 32'h1000, 8'd1);
    push_rd(63, 3); exp_done.push_back(1'b0);
    run_cmd(0, 32'h0FC0, 16'd3, 300, cyc);

    // 3: long read split into MAX_BURST pieces
    push_ax(0, 32'h0, 8'd15); push_ax(0, 32'h400, 8'd15); push_ax(0, 32'h800, 8'd7);
    push_rd(0, 40); exp_done.push_back(1'b0);
    run_cmd(0, 32'h0, 16'd40, 1000, cyc);

    // 4: misaligned address and zero length: immediate error, no bus traffic
    av_seen = 1'b0;
    exp_done.push_back(1'b1);
    run_cmd(0, 32'h1004, 16'd1, 10, cyc);
    chk("misaligned_latency", (cyc >= 1 && cyc <= 2), 1);
    exp_done.push_back(1'b1);
    run_cmd(1, 32'h0, 16'd0, 10, cyc);
    chk("zero_len_latency", (cyc >= 1 && cyc <= 2), 1);
    chk("no_addr_valid_on_error", av_seen, 0);

    // 5: error responses, then a clean command to show the flag was cleared
    bresp_err = 1'b1;
    push_ax(1, 32'h2000, 8'd1); push_wr(128, 2, 16, 1, -1); exp_done.push_back(1'b1);
    run_cmd(1, 32'h2000, 16'd2, 300, cyc);
    bresp_err = 1'b0;
    rresp_err = 1'b1;
    push_ax(0, 32'h2000, 8'd1); push_rd(128, 2); exp_done.push_back(1'b1);
    run_cmd(0, 32'h2000, 16'd2, 300, cyc);
    rresp_err = 1'b0;
    push_ax(0, 32'h1FC0, 8'd0); push_ax(0, 32'h2000, 8'd0);
    push_rd(127, 2); exp_done.push_back(1'b0);
    run_cmd(0, 32'h1FC0, 16'd2, 300, cyc);

    // 6: reset in the middle of write data, then a clean command
    push_ax(1, 32'h100, 8'd15); push_wr(4, 16, 32, 15, -1);
    w0 = w_beats;
    send_cmd(1, 32'h100, 16'd16);
    for (int i = 0; i < 300 && w_beats < w0 + 3; i++) @(posedge aclk);
    chk("wdata_in_flight", (w_beats >= w0 + 3), 1);
    @(posedge aclk); #3;
    aresetn = 1'b0;
    #1;
    chk("async_reset_outputs", out_vec(), 0);
    exp_ar.delete(); exp_aw.delete(); exp_rd.delete(); exp_w.delete(); exp_done.delete();
    wq.delete();
    for (int i = 0; i < 256; i++) model_mem[i] = pat(i);
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;
    push_ax(0, 32'h1000, 8'd3); push_rd(64, 4); exp_done.push_back(1'b0);
    run_cmd(0, 32'h1000, 16'd4, 200, cyc);

`ifdef AXI_MASTER_TIMEOUT_EN
    aw_block = 1'b1;
    wq.push_back(pat(0));
    exp_done.push_back(1'b1);
    run_cmd(1, 32'h0, 16'd1, 1200, cyc);
    wq.delete();
    aw_block = 1'b0;
`endif

    repeat (2) @(posedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
